// File: rtl/recip_pkg.sv
// Shared types, constants, seed table and result packing for the reciprocal unit.
package recip_pkg;

  typedef enum logic [2:0] {IDLE, SEED, ITER_A, ITER_B, PACK} state_t;

  typedef struct packed {
    logic nan;
    logic div_by_zero;
    logic underflow;
  } flags_t;

  localparam logic [24:0] TWO_Q2_23 = 25'h1000000;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int          EXP_BIAS  = 127;

  // Entry i = round(2^23 / (0.5 + (2i+1)/64)), Q1.23 estimate of 1/d at the interval midpoint.
  localparam logic [23:0] SEED_TABLE [16] = '{
    24'hF83E10, 24'hEA0EA1, 24'hDD67C9, 24'hD20D21,
    24'hC7CE0C, 24'hBE82FA, 24'hB60B61, 24'hAE4C41,
    24'hA72F05, 24'hA0A0A1, 24'h9A90E8, 24'h94F209,
    24'h8FB824, 24'h8AD8F3, 24'h864B8A, 24'h820821
  };

  // Biased exponent of 1/D; x lies in (1,2) for f!=0, which costs one extra step.
  function automatic logic signed [9:0] out_exp(input logic [7:0] e, input logic [22:0] f);
    logic [9:0] base;
    base = (f == 23'h0) ? 10'(2*EXP_BIAS) : 10'(2*EXP_BIAS - 1);
    return signed'(base - {2'b00, e});
  endfunction

  function automatic logic [31:0] pack_result(input logic [31:0] op, input logic [22:0] xf);
    logic [31:0]       r;
    logic signed [9:0] ex;
    ex = out_exp(op[30:23], op[22:0]);
    if (op[30:23] == 8'hFF)
      r = (op[22:0] != 23'h0) ? QNAN : {op[31], 31'h0};
    else if (op[30:23] == 8'h00)
      r = {op[31], 8'hFF, 23'h0};
    else if (ex <= 10'sd0)
      r = {op[31], 31'h0};
    else
      r = {op[31], ex[7:0], (op[22:0] == 23'h0) ? 23'h0 : xf};
    return r;
  endfunction

  function automatic flags_t pack_flags(input logic [31:0] op);
    flags_t fl;
    fl = '0;
    if (op[30:23] == 8'hFF)
      fl.nan = (op[22:0] != 23'h0);
    else if (op[30:23] == 8'h00)
      fl.div_by_zero = 1'b1;
    else
      fl.underflow = (out_exp(op[30:23], op[22:0]) <= 10'sd0);
    return fl;
  endfunction

endpackage

// File: rtl/recip_seed_lut.sv
// Combinational seed lookup: top four fraction bits select a Q1.23 reciprocal estimate.
module recip_seed_lut
  import recip_pkg::*;
(
  input  logic [3:0]  index,
  output logic [23:0] seed
);

  assign seed = SEED_TABLE[index];

endmodule

// File: rtl/recip_iter_unit.sv
// Multi-cycle float reciprocal: LUT seed plus ITER Newton-Raphson rounds on one shared multiplier.
// Optional exception flags port enabled by defining RECIP_EXC_FLAGS_EN.
module recip_iter_unit
  import recip_pkg::*;
#(
  parameter int ITER = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
`ifdef RECIP_EXC_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  localparam logic [1:0] LAST = 2'(ITER - 1);

  state_t      state;
  logic        seed_ph;
  logic [1:0]  cnt;
  logic [31:0] op_q;
  logic [23:0] seed_q;
  logic [23:0] x;
  logic [24:0] t;

  logic [23:0] lut_seed;
  logic [23:0] mant;
  logic [23:0] mul_a;
  logic [24:0] mul_b;
  logic [25:0] prod_top;
  logic [23:0] x_next;

  recip_seed_lut u_lut (
    .index (op_q[22:19]),
    .seed  (lut_seed)
  );

  assign mant = {1'b1, op_q[22:0]};

  // One multiplier: d*x in ITER_A, x*t in ITER_B. Only product bits [48:23] are ever consumed.
  assign mul_a    = (state == ITER_B) ? x : mant;
  assign mul_b    = (state == ITER_B) ? t : {1'b0, x};
  assign prod_top = 26'(({25'b0, mul_a} * {24'b0, mul_b}) >> 23);
  assign x_next   = (prod_top[25:24] != 2'b00) ? 24'hFFFFFF : prod_top[23:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      seed_ph <= 1'b0;
      cnt     <= 2'd0;
      op_q    <= 32'h0;
      seed_q  <= 24'h0;
      x       <= 24'h0;
      t       <= 25'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'h0;
`ifdef RECIP_EXC_FLAGS_EN
      flags   <= 3'b000;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= operand;
            seed_ph <= 1'b0;
            busy    <= 1'b1;
            state   <= SEED;
          end
        end
        SEED: begin
          // First cycle registers the LUT output, second loads it as x0.
          cnt <= 2'd0;
          if (!seed_ph) begin
            seed_q  <= lut_seed;
            seed_ph <= 1'b1;
          end else begin
            x     <= seed_q;
            state <= ITER_A;
          end
        end
        ITER_A: begin
          t     <= TWO_Q2_23 - {1'b0, prod_top[24:1]};
          state <= ITER_B;
        end
        ITER_B: begin
          x <= x_next;
          if (cnt == LAST) begin
            state <= PACK;
          end else begin
            cnt   <= cnt + 2'd1;
            state <= ITER_A;
          end
        end
        PACK: begin
          result <= pack_result(op_q, x[22:0]);
`ifdef RECIP_EXC_FLAGS_EN
          flags  <= pack_flags(op_q);
`endif
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_iter_unit.sv
// Directed bench for recip_iter_unit: ITER=2 instance for most checks, ITER=3 instance for accuracy.
module tb_recip_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start3;
  logic [31:0] operand;
  logic        busy, done, busy3, done3;
  logic [31:0] result, result3;
`ifdef RECIP_EXC_FLAGS_EN
  logic [2:0]  flags, flags3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  recip_iter_unit #(.ITER(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef RECIP_EXC_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  recip_iter_unit #(.ITER(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start3),
    .operand (operand),
    .busy    (busy3),
    .done    (done3),
    .result  (result3)
`ifdef RECIP_EXC_FLAGS_EN
    ,
    .flags   (flags3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operand on the ITER=2 unit and wait (bounded) for done.
  task automatic run_op(input string tag, input logic [31:0] op, output logic [31:0] res);
    int lat;
    operand = op;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (done === 1'b1) lat = k;
    end
    check({tag, " latency"}, 32'(lat), 32'd7);
    res = result;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] op,
                           input logic [31:0] exp_res, input logic [2:0] exp_flg);
    logic [31:0] res;
    run_op(tag, op, res);
    check({tag, " result"}, res, exp_res);
`ifdef RECIP_EXC_FLAGS_EN
    check({tag, " flags"}, {29'b0, flags}, {29'b0, exp_flg});
`else
    if (exp_flg === 3'bxxx) $display("note: unreachable flag pattern");
`endif
  endtask

  initial begin
    logic [31:0] res, res1, res2;
    int          lat, lat1, lat2, ndone;

    rst_n   = 1'b0;
    start   = 1'b0;
    start3  = 1'b0;
    operand = 32'h0;
    tick();
    tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'h0);
    check("reset busy3", {31'b0, busy3}, 32'd0);
    check("reset result3", result3, 32'h0);
`ifdef RECIP_EXC_FLAGS_EN
    check("reset flags", {29'b0, flags}, 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Powers of two and simple values
    expect_op("two",     32'h40000000, 32'h3F000000, 3'b000);
    expect_op("neg_one", 32'hBF800000, 32'hBF800000, 3'b000);
    expect_op("one",     32'h3F800000, 32'h3F800000, 3'b000);
    expect_op("eight",   32'h41000000, 32'h3E000000, 3'b000);

    // 3.0 on ITER=2: within 4 ulp of 0x3EAAAAAB
    run_op("three", 32'h40400000, res);
    check("three ulp4", {31'b0, (res >= 32'h3EAAAAA7) && (res <= 32'h3EAAAAAF)}, 32'd1);

    // Special operands
    expect_op("pos_zero", 32'h00000000, 32'h7F800000, 3'b010);
    expect_op("neg_zero", 32'h80000000, 32'hFF800000, 3'b010);
    expect_op("denorm",   32'h00400000, 32'h7F800000, 3'b010);
    expect_op("nan",      32'h7F800001, 32'h7FC00000, 3'b100);
    expect_op("neg_nan",  32'hFFC00000, 32'h7FC00000, 3'b100);
    expect_op("neg_inf",  32'hFF800000, 32'h80000000, 3'b000);

    // Underflow boundaries
    expect_op("uf_e253",  32'h7EC00000, 32'h00000000, 3'b001);
    expect_op("uf_e254",  32'h7F000000, 32'h00000000, 3'b001);
    expect_op("uf_max",   32'h7F7FFFFF, 32'h00000000, 3'b001);

    // 3.0 on ITER=3: within 2 ulp, done 9 cycles after start
    operand = 32'h40400000;
    start3  = 1'b1;
    tick();
    start3 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (done3 === 1'b1) lat = k;
    end
    check("three_it3 latency", 32'(lat), 32'd9);
    check("three_it3 ulp2", {31'b0, (result3 >= 32'h3EAAAAA9) && (result3 <= 32'h3EAAAAAD)}, 32'd1);

    // Second start two cycles after acceptance is dropped
    operand = 32'h40000000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    operand = 32'h3F800000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("ignore busy", {31'b0, busy}, 32'd1);
    ndone = 0;
    lat   = 0;
    res   = 32'h0;
    for (int k = 3; k <= 20; k++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = k;
          res = result;
        end
      end
    end
    check("ignore done count", 32'(ndone), 32'd1);
    check("ignore latency", 32'(lat), 32'd7);
    check("ignore result", res, 32'h3F000000);

    // start held high: re-accepted in the done cycle
    operand = 32'h40000000;
    start   = 1'b1;
    tick();
    ndone = 0;
    lat1  = 0;
    lat2  = 0;
    res1  = 32'h0;
    res2  = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2)  operand = 32'h40800000;
      if (k == 10) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (lat1 == 0) begin
          lat1 = k;
          res1 = result;
          check("held busy at done", {31'b0, busy}, 32'd0);
        end else if (lat2 == 0) begin
          lat2 = k;
          res2 = result;
        end
      end
    end
    check("held done count", 32'(ndone), 32'd2);
    check("held first latency", 32'(lat1), 32'd7);
    check("held second latency", 32'(lat2), 32'd15);
    check("held first result", res1, 32'h3F000000);
    check("held second result", res2, 32'h3E800000);

    // Reset pulse while in ITER_B aborts the operation
    operand = 32'h40000000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'h0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    expect_op("after_abort", 32'h40800000, 32'h3E800000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/recip_iter_unit.md
# recip_iter_unit

Multi-cycle IEEE-754 single-precision reciprocal unit for the root calculator datapath. It accepts one operand per start pulse, unpacks it, seeds a reciprocal estimate from a LUT, and runs a parameterised number of Newton-Raphson refinements x = x·(2 − d·x) on one shared 24×25 multiplier. It then packs and registers a float result with a done pulse. It feeds reciprocals into the divide and root paths and replaces the fully unrolled combinational stages where area matters.

## Interface
- ITER, 2, number of Newton-Raphson iterations (1–4)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- start  in  1  request; sampled only in IDLE
- operand  in  32  IEEE-754 single-precision input D
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse, result valid
- result  out  32  reciprocal 1/D; held until the next done
- flags  out  3  {nan, div_by_zero, underflow}; valid with done (present only under RECIP_EXC_FLAGS_EN)

## Operation
- Unpack: s = operand[31], E = operand[30:23], f = operand[22:0], m = {1,f} (Q1.23), d = m/2 (Q0.24, range [0.5,1)).
- Seed: x0 = LUT[f[22:19]] in Q1.23. Entry i = round(2^23 / (0.5 + (2i+1)/64)). Example: entry 0 = 0xF83E10.
- Iteration, two states:
  - ITER_A computes p = d·x (48 b, Q1.47) and e = p[47:24]. The register then holds t = 25'h1000000 − e (Q2.23).
  - ITER_B computes q = x·t (49 b) and sets x = q[46:23]. It saturates to 24'hFFFFFF if q[48:47] ≠ 0.
- Pack, in priority order:
  - E=255, f≠0: 0x7FC00000, nan.
  - E=255, f=0: {s,31'h0}.
  - E=0 (zero or denormal): {s,8'hFF,23'h0}, div_by_zero.
  - f=0: exponent 254−E, fraction 0. Flush to {s,31'h0} with underflow if 254−E ≤ 0.
  - Otherwise: exponent 253−E, fraction x[22:0]. Flush to {s,31'h0} with underflow if 253−E ≤ 0.
- Truncation throughout, no rounding. Accuracy: within 4 ulp of correctly rounded for ITER=2, 2 ulp for ITER≥3.
- FSM: IDLE →(start) SEED → ITER_A ↔ ITER_B (ITER rounds, iteration counter) → PACK → IDLE.
  - Special operands traverse all states.
  - The iteration counter counts 0..ITER−1 and resets in SEED.
- start while busy: ignored, not queued. start in the PACK cycle: ignored. start in the cycle done is high (FSM already in IDLE): accepted.

## Timing
- Fixed latency: done asserts 2·ITER+3 cycles after the clk edge that samples start (7 for ITER=2). Result and flags update on that same edge.
- busy is high in SEED, ITER_A, ITER_B and PACK. It drops on the edge that raises done.
- Reset: state IDLE, busy 0, done 0, result 0, flags 0, counter 0. Reset mid-operation aborts immediately. No done follows and result returns to 0.
- Throughput: one operation per 2·ITER+3 cycles.

## Configuration
- RECIP_EXC_FLAGS_EN defined: the flags port exists and its registers update at PACK; reset value 0.
- Undefined: no flags port or registers. Result encoding is unchanged.

## Structure
- recip_pkg holds:
  - FSM state enum (IDLE, SEED, ITER_A, ITER_B, PACK)
  - 16-entry seed constant array
  - constants TWO_Q2_23 = 25'h1000000, QNAN = 32'h7FC00000, EXP_BIAS = 127
- Sub-module recip_seed_lut: combinational, index[3:0] → seed[23:0], contents from recip_pkg.
- A single multiplier instance is muxed between the d·x and x·t operand pairs.

## Test plan
- 0x40000000 (2.0), ITER=2 → result 0x3F000000, done exactly 7 cycles after start; 0xBF800000 → 0xBF800000.
- 0x40400000 (3.0) → result within 4 ulp of 0x3EAAAAAB. With ITER=3 → within 2 ulp.
- 0x00000000 → 0x7F800000, div_by_zero; 0x80000000 → 0xFF800000; 0x7F800001 → 0x7FC00000, nan; 0xFF800000 → 0x80000000.
- 0x7EC00000 (E=253, f≠0) → 0x00000000, underflow; 0x7F000000 (E=254, f=0) → 0x00000000, underflow.
- start pulsed again 2 cycles after acceptance → ignored, single done. start held high → new operation accepted in the done cycle, done again 7 cycles later.
- rst_n low during ITER_B for one cycle → busy 0, result 0, no done. A subsequent start of 0x40800000 → 0x3E800000.
